hazard_forward_ctrl: RTL and testbench

//  Sequencing controller for the EX-stage operand muxes of the 5-stage MIPS pipeline.

---
 rtl/hazard_forward_ctrl_pkg.sv | 28 ++
 rtl/hazard_forward_ctrl_if.sv | 38 +++
 rtl/hazard_forward_ctrl_stage.sv | 20 ++
 rtl/hazard_forward_ctrl.sv | 131 +++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants for the EX-stage forwarding controller: mux select codes,
// the hard-wired zero register and the bit layout of a pipeline stage record.
package hazard_forward_ctrl_pkg;

    // Operand mux select encoding; 2'b11 is never driven.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_WB      = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    localparam int REG_ZERO = 0;

    // Stage record packed as {dst, mem_read, reg_write, valid}, LSB first.
    localparam int REC_VALID     = 0;
    localparam int REC_REG_WRITE = 1;
    localparam int REC_MEM_READ  = 2;
    localparam int REC_DST_LSB   = 3;

    typedef enum logic [1:0] {
        STG_EX  = 2'd0,
        STG_MEM = 2'd1,
        STG_WB  = 2'd2
    } stage_e;

    function automatic int rec_width(input int reg_aw);
        return reg_aw + REC_DST_LSB;
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage instruction fields in, forwarding selects / stall / debug out.
// stall acts as the not-ready of the ID stage: an ID instruction is accepted
// on a posedge only when id_valid=1, stall=0 and flush=0; otherwise it is held.
interface hazard_forward_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    localparam int REC_W = REG_AW + 3;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_AW-1:0] id_dst;
    logic              id_reg_write;
    logic              id_mem_read;
    logic              flush;

    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic [CNT_W-1:0]  stall_count;
    logic [3*REC_W-1:0] pipe_dbg;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_reg_write, id_mem_read, flush,
        input  fwd_a_sel, fwd_b_sel, stall, stall_count, pipe_dbg
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
               id_dst, id_reg_write, id_mem_read, flush,
        output fwd_a_sel, fwd_b_sel, stall, stall_count, pipe_dbg
    );

endinterface

// File: rtl/hazard_forward_ctrl_stage.sv
// One pipeline stage record (valid, dst, reg_write, mem_read) with a
// synchronous active-low clear.
module hazard_stage_reg #(
    parameter int REC_W = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [REC_W-1:0] d,
    output logic [REC_W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX operand forwarding and load-use stall controller for a 5-stage pipeline.
// Shadows in-flight destinations and registers the operand mux selects.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input logic                 clk,
    input logic                 rst_n,
    hazard_forward_ctrl_if.slave bus
);

    localparam int REC_W = rec_width(REG_AW);

    logic [REC_W-1:0] ex_rec;
    logic [REC_W-1:0] mem_rec;
    logic [REC_W-1:0] wb_rec;
    logic [REC_W-1:0] new_rec;

    logic             issue;
    logic             stall_c;
    logic             load_use_a;
    logic             load_use_b;
    logic [1:0]       sel_a_c;
    logic [1:0]       sel_b_c;
    logic [1:0]       fwd_a_q;
    logic [1:0]       fwd_b_q;
    logic [CNT_W-1:0] stall_count_q;

    function automatic logic rec_match(
        input logic [REC_W-1:0]  rec,
        input logic [REG_AW-1:0] r
    );
        logic [REG_AW-1:0] dst;
        dst = rec[REC_DST_LSB +: REG_AW];
        return rec[REC_VALID] & rec[REC_REG_WRITE] &
               (dst != REG_AW'(REG_ZERO)) & (dst == r);
    endfunction

    // EX/MEM (younger) beats MEM/WB; the WB-stage producer relies on a
    // write-before-read register file and is never forwarded.
    function automatic logic [1:0] fwd_select(
        input logic [REC_W-1:0]  ex_r,
        input logic [REC_W-1:0]  mem_r,
        input logic [REG_AW-1:0] r,
        input logic              use_r
    );
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (use_r && rec_match(ex_r, r)) begin
            sel = FWD_MEM;
        end else if (use_r && rec_match(mem_r, r)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        load_use_a = bus.id_use_rs & rec_match(ex_rec, bus.id_rs);
        load_use_b = bus.id_use_rt & rec_match(ex_rec, bus.id_rt);
        stall_c    = bus.id_valid & ~bus.flush & ex_rec[REC_MEM_READ] &
                     (load_use_a | load_use_b);
        issue      = bus.id_valid & ~stall_c & ~bus.flush;
    end

    always_comb begin
        new_rec = '0;
        if (issue) begin
            new_rec[REC_VALID]               = 1'b1;
            new_rec[REC_REG_WRITE]           = bus.id_reg_write;
            new_rec[REC_MEM_READ]            = bus.id_mem_read;
            new_rec[REC_DST_LSB +: REG_AW]   = bus.id_dst;
        end
    end

    always_comb begin
        sel_a_c = FWD_REGFILE;
        sel_b_c = FWD_REGFILE;
        if (issue) begin
            sel_a_c = fwd_select(ex_rec, mem_rec, bus.id_rs, bus.id_use_rs);
            sel_b_c = fwd_select(ex_rec, mem_rec, bus.id_rt, bus.id_use_rt);
        end
    end

    hazard_stage_reg #(.REC_W(REC_W)) u_stage_ex (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (new_rec),
        .q     (ex_rec)
    );

    hazard_stage_reg #(.REC_W(REC_W)) u_stage_mem (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (ex_rec),
        .q     (mem_rec)
    );

    hazard_stage_reg #(.REC_W(REC_W)) u_stage_wb (
        .clk   (clk),
        .clr_n (rst_n),
        .d     (mem_rec),
        .q     (wb_rec)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_a_q <= FWD_REGFILE;
            fwd_b_q <= FWD_REGFILE;
        end else begin
            fwd_a_q <= sel_a_c;
            fwd_b_q <= sel_b_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else if (stall_c && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + CNT_W'(1);
        end
    end

    assign bus.fwd_a_sel   = fwd_a_q;
    assign bus.fwd_b_sel   = fwd_b_q;
    assign bus.stall       = stall_c;
    assign bus.stall_count = stall_count_q;
    assign bus.pipe_dbg    = {wb_rec, mem_rec, ex_rec};

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed hazard scenarios followed by random instruction streams, checked
// against a three-entry in-flight instruction history model.
module tb_hazard_forward_ctrl;
    import hazard_forward_ctrl_pkg::*;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 4;
    localparam int REC_W  = REG_AW + 3;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    hazard_forward_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // History of issued instructions: hist[0] in EX, hist[1] in MEM, hist[2] in WB.
    typedef struct {
        bit       valid;
        bit [4:0] dst;
        bit       rw;
        bit       mr;
    } ent_t;

    ent_t     hist [3];
    bit [1:0] m_sel_a;
    bit [1:0] m_sel_b;
    int       m_cnt;
    bit       last_stall;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writes(ent_t e, bit [4:0] r);
        return e.valid && e.rw && (r != 0) && (e.dst == r);
    endfunction

    function automatic bit [1:0] pick(bit [4:0] r, bit use_r);
        if (!use_r) return 2'd0;
        if (writes(hist[0], r)) return 2'd2;
        if (writes(hist[1], r)) return 2'd1;
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) hist[i] = '{valid: 0, dst: 0, rw: 0, mr: 0};
        m_sel_a = 0;
        m_sel_b = 0;
        m_cnt   = 0;
    endtask

    task automatic cycle(input bit rst, input bit v, input bit [4:0] rs, input bit [4:0] rt,
                         input bit urs, input bit urt, input bit [4:0] dst,
                         input bit rw, input bit mr, input bit fl);
        bit   exp_stall;
        bit   issue;
        logic [2:0] vbits;
        @(negedge clk);
        rst_n            = rst;
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_use_rs    = urs;
        bus.id_use_rt    = urt;
        bus.id_dst       = dst;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.flush        = fl;
        #1;
        exp_stall = v && !fl && hist[0].mr &&
                    ((urs && writes(hist[0], rs)) || (urt && writes(hist[0], rt)));
        check("stall", 32'(bus.stall), 32'(exp_stall));
        last_stall = exp_stall;
        issue = v && !exp_stall && !fl;
        if (!rst) begin
            model_clear();
        end else begin
            m_sel_a = issue ? pick(rs, urs) : 2'd0;
            m_sel_b = issue ? pick(rt, urt) : 2'd0;
            if (exp_stall && m_cnt < CMAX) m_cnt++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (issue) hist[0] = '{valid: 1, dst: dst, rw: rw, mr: mr};
            else       hist[0] = '{valid: 0, dst: 0, rw: 0, mr: 0};
        end
        @(posedge clk);
        #1;
        vbits = {bus.pipe_dbg[2*REC_W+REC_VALID], bus.pipe_dbg[REC_W+REC_VALID],
                 bus.pipe_dbg[REC_VALID]};
        check("fwd_a_sel", 32'(bus.fwd_a_sel), 32'(m_sel_a));
        check("fwd_b_sel", 32'(bus.fwd_b_sel), 32'(m_sel_b));
        check("stall_count", 32'(bus.stall_count), 32'(m_cnt));
        check("stage_valid", 32'(vbits), 32'({hist[2].valid, hist[1].valid, hist[0].valid}));
    endtask

    task automatic alu(input bit [4:0] rd, input bit [4:0] rs, input bit [4:0] rt);
        cycle(1, 1, rs, rt, 1, 1, rd, 1, 0, 0);
    endtask

    task automatic lw(input bit [4:0] rt, input bit [4:0] base);
        cycle(1, 1, base, rt, 1, 0, rt, 1, 1, 0);
    endtask

    task automatic nop();
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bit [4:0] rs, rt, dst;
        bit       v, urs, urt, rw, mr, fl, rst;

        rst_n = 1'b0;
        bus.id_valid = 0; bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0;
        bus.id_use_rt = 0; bus.id_dst = 0; bus.id_reg_write = 0;
        bus.id_mem_read = 0; bus.flush = 0;
        model_clear();
        last_stall = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_fwd_a", 32'(bus.fwd_a_sel), 32'd0);
        check("reset_fwd_b", 32'(bus.fwd_b_sel), 32'd0);
        check("reset_count", 32'(bus.stall_count), 32'd0);
        check("reset_stall", 32'(bus.stall), 32'd0);

        // ALU -> ALU back to back
        nop();
        alu(3, 1, 2);
        alu(4, 3, 5);
        check("t1_fwd_a", 32'(bus.fwd_a_sel), 32'd2);
        check("t1_fwd_b", 32'(bus.fwd_b_sel), 32'd0);

        // Distance 2 and distance 3
        alu(3, 1, 2); nop(); alu(6, 1, 3);
        check("t2_dist2_b", 32'(bus.fwd_b_sel), 32'd1);
        alu(3, 1, 2); nop(); nop(); alu(6, 1, 3);
        check("t2_dist3_b", 32'(bus.fwd_b_sel), 32'd0);

        // Load-use: one stall cycle, bubble, then WB forwarding on both operands
        nop(); nop();
        lw(2, 1);
        alu(7, 2, 2);
        check("t3_stall_seen", 32'(last_stall), 32'd1);
        check("t3_bubble", 32'(bus.pipe_dbg[REC_VALID]), 32'd0);
        check("t3_count", 32'(bus.stall_count), 32'd1);
        alu(7, 2, 2);
        check("t3_stall_once", 32'(last_stall), 32'd0);
        check("t3_fwd_a", 32'(bus.fwd_a_sel), 32'd1);
        check("t3_fwd_b", 32'(bus.fwd_b_sel), 32'd1);

        // Two producers of $3: the younger wins, $0 never forwards
        alu(3, 1, 2); alu(3, 4, 5); alu(8, 3, 0);
        check("t4_fwd_a", 32'(bus.fwd_a_sel), 32'd2);
        check("t4_fwd_b", 32'(bus.fwd_b_sel), 32'd0);

        // Flush beats load-use
        lw(2, 1);
        cycle(1, 1, 2, 2, 1, 1, 7, 1, 0, 1);
        check("t5_stall", 32'(last_stall), 32'd0);
        check("t5_ex_valid", 32'(bus.pipe_dbg[REC_VALID]), 32'd0);
        check("t5_fwd_a", 32'(bus.fwd_a_sel), 32'd0);
        check("t5_count", 32'(bus.stall_count), 32'd1);

        // Reset with three writers in flight
        alu(3, 1, 2); alu(5, 1, 2); lw(6, 1);
        cycle(0, 1, 6, 3, 1, 1, 9, 1, 0, 0);
        check("t6_fwd_a", 32'(bus.fwd_a_sel), 32'd0);
        check("t6_count", 32'(bus.stall_count), 32'd0);
        cycle(1, 1, 6, 3, 1, 1, 9, 1, 0, 0);
        check("t6_no_stall", 32'(last_stall), 32'd0);
        check("t6_dep_a", 32'(bus.fwd_a_sel), 32'd0);
        check("t6_dep_b", 32'(bus.fwd_b_sel), 32'd0);

        // Random streams; a stalled instruction is re-presented unchanged
        for (int n = 0; n < 2000; n++) begin
            if (!last_stall) begin
                v   = ($urandom_range(0, 99) < 85);
                rs  = 5'($urandom_range(0, 7));
                rt  = 5'($urandom_range(0, 7));
                dst = 5'($urandom_range(0, 7));
                urs = ($urandom_range(0, 9) < 8);
                urt = ($urandom_range(0, 9) < 6);
                rw  = ($urandom_range(0, 9) < 8);
                mr  = rw && ($urandom_range(0, 9) < 4);
            end
            fl  = ($urandom_range(0, 99) < 8);
            rst = ($urandom_range(0, 199) != 0);
            cycle(rst, v, rs, rt, urs, urt, dst, rw, mr, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
